mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-port arbiter that shares the single cache-block transfer path (cache data transfer unit, AXI4-Lite master, simulated memory) between the instruction-cache port (port 0) and the data-cache port (port 1). It accepts block read/write requests from both ports and grants exactly one transfer at a time, with round-robin fairness. It returns the completed block and a done pulse to the owning port, and aborts hung transfers with a timeout. It sits between the two cache controllers and the transfer unit's start/address/block/done handshake.

## Interface

- ADDR_WIDTH, 64, request/transfer address width
- BLOCK_WIDTH, 128, cache block width
- TIMEOUT_CYCLES, 1024, max cycles in BUSY before abort; 0 disables timeout (counter width = $clog2(TIMEOUT_CYCLES+1))

Ports:

- i_clk  in  1  single clock; all state on rising edge
- i_arst  in  1  reset, asynchronous, active-low
- i_req_read  in  2  per-port block read request; level, held until that port's o_req_done or o_req_timeout
- i_req_write  in  2  per-port block write-back request; same hold rule
- i_req_addr_0 / i_req_addr_1  in  ADDR_WIDTH  per-port block address
- i_req_block_0 / i_req_block_1  in  BLOCK_WIDTH  per-port write-back block
- o_req_done  out  2  one-cycle completion pulse to owning port
- o_req_timeout  out  2  one-cycle abort pulse to owning port
- o_rsp_block  out  BLOCK_WIDTH  last completed read block, shared by both ports
- o_start_read  out  1  read start to transfer unit
- o_start_write  out  1  write start to transfer unit
- o_addr  out  ADDR_WIDTH  address to transfer unit
- o_block  out  BLOCK_WIDTH  write block to transfer unit
- i_done  in  1  transfer-complete pulse from transfer unit
- i_block  in  BLOCK_WIDTH  read block from transfer unit, valid with i_done
- o_busy  out  1  high in BUSY and DONE
- o_owner  out  1  current/last granted port

## Operation

- States:
  - IDLE: no transfer.
  - BUSY: one transfer in flight.
  - DONE: one-cycle release.
- Port request: req_p = i_req_read[p] | i_req_write[p].
- Intra-port: if read and write are both high on one port, the write is granted first (write-back before refill). The read stays pending and is arbitrated again later.
- Inter-port: round-robin on a priority bit prio. With one requester, grant it. With two, grant port prio. On grant, prio ← ~granted port.
- IDLE → BUSY on any req. At the transition, register owner, op (read/write) and zero the timeout counter.
- BUSY:
  - o_start_read = (op==read) and o_start_write = (op==write), both registered.
  - o_addr and o_block mux from the owner's inputs.
  - The timeout counter increments each cycle.
- BUSY → DONE on i_done:
  - Pulse o_req_done[owner].
  - If op==read, o_rsp_block ← i_block.
  - Drop both starts.
- BUSY → DONE on timeout:
  - Condition: TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES−1 with no i_done.
  - Pulse o_req_timeout[owner] and drop starts. o_rsp_block is unchanged.
- i_done and timeout in the same cycle: done wins and no timeout pulse is issued.
- DONE → IDLE unconditionally. Requests are ignored in DONE, which gives the owning port one cycle to drop its request.
- i_done seen in IDLE or DONE is ignored.
- Changes to the owner's request inputs during BUSY are ignored. op and owner are latched; addr and block must be held stable by the requester.
- Reset (any time, including mid-transfer) returns state to IDLE. Outputs then take their reset values: all outputs 0, prio=0, owner=0, counter 0, o_rsp_block 0. The aborted transfer is not reported.

## Timing

- Request seen in IDLE at edge t: o_start_* high from t+1. o_busy high from t+1.
- i_done high in cycle c: o_req_done and o_rsp_block update at c+1, starts low at c+1. State is IDLE at c+2.
- Earliest next grant: request seen at c+2, start at c+3. Minimum turnaround between transfers is 2 idle-start cycles.
- Timeout: starts drop exactly TIMEOUT_CYCLES cycles after they rise.
- o_req_done and o_req_timeout are single-cycle and mutually exclusive. At most one bit of either is high.
- o_start_read and o_start_write are never high together.

## Test plan

- Port 1 read only, addr 0x40, transfer done 5 cycles after start with i_block=0xA5…A5:
  - o_start_read high from cycle 1.
  - o_addr=0x40.
  - o_req_done=2'b10 one cycle.
  - o_rsp_block=0xA5…A5.
  - o_busy low 2 cycles after done.
- Both ports request reads continuously from reset:
  - Grants alternate 0,1,0,1.
  - o_owner sequence matches.
  - No port is granted twice in a row.
- Port 0 asserts read and write together, addr 0x100:
  - Write granted first with o_block=i_req_block_0.
  - After its done, read granted (if port 1 idle).
  - o_rsp_block updated only on the read.
- TIMEOUT_CYCLES=8, i_done never asserted:
  - o_start high 8 cycles.
  - o_req_timeout[owner] one-cycle pulse.
  - o_rsp_block unchanged.
  - Next request granted normally.
- i_done and the timeout terminal cycle coincide:
  - Only o_req_done pulses.
  - o_rsp_block captured.
- i_arst low mid-BUSY for port 1:
  - All outputs 0 asynchronously.
  - After release, a port-0 request is granted first (prio=0).
  - No stale done pulse.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// =====================================================================
// mem_port_arbiter_if: request/response and transfer-unit handshake bundle
// Revision: 1.0
// =====================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 128
);
  logic [1:0]             i_req_read;
  logic [1:0]             i_req_write;
  logic [ADDR_WIDTH-1:0]  i_req_addr_0;
  logic [ADDR_WIDTH-1:0]  i_req_addr_1;
  logic [BLOCK_WIDTH-1:0] i_req_block_0;
  logic [BLOCK_WIDTH-1:0] i_req_block_1;
  logic [1:0]             o_req_done;
  logic [1:0]             o_req_timeout;
  logic [BLOCK_WIDTH-1:0] o_rsp_block;
  logic                   o_start_read;
  logic                   o_start_write;
  logic [ADDR_WIDTH-1:0]  o_addr;
  logic [BLOCK_WIDTH-1:0] o_block;
  logic                   i_done;
  logic [BLOCK_WIDTH-1:0] i_block;
  logic                   o_busy;
  logic                   o_owner;

  // Arbiter side.
  modport master (
    input  i_req_read, i_req_write, i_req_addr_0, i_req_addr_1,
           i_req_block_0, i_req_block_1, i_done, i_block,
    output o_req_done, o_req_timeout, o_rsp_block, o_start_read,
           o_start_write, o_addr, o_block, o_busy, o_owner
  );

  // Cache-port / transfer-unit side.
  modport slave (
    output i_req_read, i_req_write, i_req_addr_0, i_req_addr_1,
           i_req_block_0, i_req_block_1, i_done, i_block,
    input  o_req_done, o_req_timeout, o_rsp_block, o_start_read,
           o_start_write, o_addr, o_block, o_busy, o_owner
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// =====================================================================
// mem_port_arbiter: round-robin sharing of one block-transfer path by two cache ports
// Revision: 1.0
// =====================================================================
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int BLOCK_WIDTH    = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              i_clk,
  input  logic              i_arst,
  mem_port_arbiter_if.master bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   prio_q, prio_d;
  logic                   owner_q, owner_d;
  logic                   op_wr_q, op_wr_d;
  logic                   start_rd_q, start_rd_d;
  logic                   start_wr_q, start_wr_d;
  logic [1:0]             done_q, done_d;
  logic [1:0]             timeout_q, timeout_d;
  logic [BLOCK_WIDTH-1:0] rsp_q, rsp_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [1:0] req;
  logic       grant;
  logic       timeout_hit;

  assign req         = bus.i_req_read | bus.i_req_write;
  assign grant       = (req[0] & req[1]) ? prio_q : req[1];
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    op_wr_d    = op_wr_q;
    start_rd_d = start_rd_q;
    start_wr_d = start_wr_q;
    done_d     = 2'b00;
    timeout_d  = 2'b00;
    rsp_d      = rsp_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          // A port asking for both gets its write-back first; the read stays pending.
          state_d    = ST_BUSY;
          owner_d    = grant;
          op_wr_d    = bus.i_req_write[grant];
          start_wr_d = bus.i_req_write[grant];
          start_rd_d = ~bus.i_req_write[grant];
          prio_d     = ~grant;
          cnt_d      = '0;
        end
      end
      ST_BUSY: begin
        if (bus.i_done) begin
          state_d         = ST_DONE;
          done_d[owner_q] = 1'b1;
          start_rd_d      = 1'b0;
          start_wr_d      = 1'b0;
          if (!op_wr_q) rsp_d = bus.i_block;
        end else if (timeout_hit) begin
          state_d            = ST_DONE;
          timeout_d[owner_q] = 1'b1;
          start_rd_d         = 1'b0;
          start_wr_d         = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q    <= ST_IDLE;
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      op_wr_q    <= 1'b0;
      start_rd_q <= 1'b0;
      start_wr_q <= 1'b0;
      done_q     <= 2'b00;
      timeout_q  <= 2'b00;
      rsp_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      owner_q    <= owner_d;
      op_wr_q    <= op_wr_d;
      start_rd_q <= start_rd_d;
      start_wr_q <= start_wr_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      rsp_q      <= rsp_d;
      cnt_q      <= cnt_d;
    end
  end

  // Address/block follow the owner's live inputs only while a transfer is in flight.
  assign bus.o_addr        = (state_q == ST_BUSY) ?
                             (owner_q ? bus.i_req_addr_1 : bus.i_req_addr_0) : '0;
  assign bus.o_block       = (state_q == ST_BUSY) ?
                             (owner_q ? bus.i_req_block_1 : bus.i_req_block_0) : '0;
  assign bus.o_start_read  = start_rd_q;
  assign bus.o_start_write = start_wr_q;
  assign bus.o_req_done    = done_q;
  assign bus.o_req_timeout = timeout_q;
  assign bus.o_rsp_block   = rsp_q;
  assign bus.o_busy        = (state_q != ST_IDLE);
  assign bus.o_owner       = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// =====================================================================
// tb_mem_port_arbiter: randomized scoreboard bench with a queue-based arbitration model
// Revision: 1.0
// =====================================================================
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int BW = 128;
  localparam int T  = 8;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .TIMEOUT_CYCLES(T)
  ) dut (
    .i_clk (clk),
    .i_arst(arst),
    .bus   (bus)
  );

  typedef struct { logic port; logic wr; logic [AW-1:0] addr; logic [BW-1:0] blk; } grant_t;
  typedef struct { int k; logic [BW-1:0] blk; } plan_t;  // k<0: never answer
  typedef struct { logic to; logic port; logic [BW-1:0] rsp; int len; } comp_t;

  grant_t gq[$];
  plan_t  pq[$];
  comp_t  cq[$];

  int total = 0;
  int bad   = 0;

  logic          m_prio = 1'b0;
  logic [BW-1:0] m_rsp  = '0;

  logic  act  = 1'b0;
  int    kcnt = 0;
  plan_t cur;

  task automatic chk(input string name, input logic [255:0] act_v, input logic [255:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end
  endtask

  function automatic logic [BW-1:0] rblk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [AW-1:0] raddr();
    return {$urandom(), $urandom()};
  endfunction

  // One negedge worth of requester and transfer-unit behaviour.
  task automatic drive_cycle();
    for (int p = 0; p < 2; p++) begin
      if (bus.o_req_done[p] | bus.o_req_timeout[p]) begin
        if (bus.i_req_write[p]) bus.i_req_write[p] = 1'b0;
        else                    bus.i_req_read[p]  = 1'b0;
      end
    end
    bus.i_done = 1'b0;
    if (bus.o_start_read | bus.o_start_write) begin
      if (!act) begin
        chk("plan_avail", pq.size() > 0, 1);
        if (pq.size() > 0) cur = pq.pop_front();
        else               cur = '{-1, '0};
        act  = 1'b1;
        kcnt = 0;
      end
      if (cur.k == kcnt) begin
        bus.i_done  = 1'b1;
        bus.i_block = cur.blk;
      end
      kcnt++;
    end else begin
      act = 1'b0;
      if (!bus.o_busy && $urandom_range(7) == 0) begin
        bus.i_done  = 1'b1;
        bus.i_block = rblk();
      end
    end
  endtask

  // rq = {write, read}; fixk: -2 random, -1 never answer, else fixed done offset.
  task automatic run_round(input logic [1:0] rq0, input logic [1:0] rq1,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                           input int fixk, input logic [BW-1:0] fixblk);
    logic q0[$];
    logic q1[$];
    logic g, op;
    int k, n;
    logic [BW-1:0] pb;
    if (rq0[1]) q0.push_back(1'b1);
    if (rq0[0]) q0.push_back(1'b0);
    if (rq1[1]) q1.push_back(1'b1);
    if (rq1[0]) q1.push_back(1'b0);
    while (q0.size() + q1.size() > 0) begin
      if (q0.size() > 0 && q1.size() > 0) g = m_prio;
      else                                g = (q1.size() > 0);
      op     = g ? q1.pop_front() : q0.pop_front();
      m_prio = ~g;
      if (fixk == -2) k = ($urandom_range(5) == 0) ? -1 : int'($urandom_range(T - 1));
      else            k = fixk;
      pb = (fixk == -2) ? rblk() : fixblk;
      gq.push_back('{g, op, g ? a1 : a0, g ? b1 : b0});
      pq.push_back('{k, pb});
      if (k < 0) cq.push_back('{1'b1, g, m_rsp, T});
      else begin
        if (!op) m_rsp = pb;
        cq.push_back('{1'b0, g, m_rsp, k + 1});
      end
    end
    bus.i_req_addr_0  = a0;
    bus.i_req_addr_1  = a1;
    bus.i_req_block_0 = b0;
    bus.i_req_block_1 = b1;
    bus.i_req_write   = {rq1[1], rq0[1]};
    bus.i_req_read    = {rq1[0], rq0[0]};
    n = 0;
    do begin
      @(negedge clk);
      drive_cycle();
      n++;
    end while ((((bus.i_req_read | bus.i_req_write) != 2'b00) || bus.o_busy) && n < 400);
    chk("round_finish", n < 400, 1);
    bus.i_req_read  = 2'b00;
    bus.i_req_write = 2'b00;
    @(negedge clk);
    drive_cycle();
    chk("queues_drained", gq.size() + cq.size() + pq.size(), 0);
  endtask

  // Monitor: pops the scoreboard whenever a grant or completion appears.
  initial begin
    logic prev  = 1'b0;
    logic after = 1'b0;
    logic st;
    int   run   = 0;
    logic [3:0] pulses, expv;
    logic [1:0] onehot;
    grant_t g;
    comp_t  c;
    forever begin
      @(negedge clk);
      if (!arst) begin
        prev = 1'b0; run = 0; after = 1'b0;
        continue;
      end
      st = bus.o_start_read | bus.o_start_write;
      if (after) chk("busy_after_release", bus.o_busy, 0);
      after = 1'b0;
      if (st) chk("start_exclusive", bus.o_start_read & bus.o_start_write, 0);
      if (st && !prev) begin
        chk("grant_expected", gq.size() > 0, 1);
        if (gq.size() > 0) begin
          g = gq.pop_front();
          chk("owner", bus.o_owner, g.port);
          chk("op", {bus.o_start_write, bus.o_start_read}, g.wr ? 2'b10 : 2'b01);
          chk("addr", bus.o_addr, g.addr);
          if (g.wr) chk("wblock", bus.o_block, g.blk);
          chk("busy_in_xfer", bus.o_busy, 1);
        end
        run = 0;
      end
      if (st) run++;
      pulses = {bus.o_req_timeout, bus.o_req_done};
      if (pulses != 4'b0000) begin
        chk("completion_expected", cq.size() > 0, 1);
        if (cq.size() > 0) begin
          c      = cq.pop_front();
          onehot = 2'b01 << c.port;
          expv   = c.to ? {onehot, 2'b00} : {2'b00, onehot};
          chk("completion", pulses, expv);
          chk("rsp_block", bus.o_rsp_block, c.rsp);
          chk("start_len", run, c.len);
          chk("busy_in_done", bus.o_busy, 1);
        end
        after = 1'b1;
      end
      prev = st;
    end
  end

  initial begin
    logic [BW-1:0] a5;
    logic [AW-1:0] ra;
    int n;
    a5 = {16{8'hA5}};
    bus.i_req_read = 2'b00; bus.i_req_write = 2'b00;
    bus.i_req_addr_0 = '0; bus.i_req_addr_1 = '0;
    bus.i_req_block_0 = '0; bus.i_req_block_1 = '0;
    bus.i_done = 1'b0; bus.i_block = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {bus.o_req_done, bus.o_req_timeout, bus.o_start_read,
                       bus.o_start_write, bus.o_busy, bus.o_owner}, 0);
    chk("reset_rsp", bus.o_rsp_block, 0);
    arst = 1'b1;
    @(negedge clk);

    run_round(2'b00, 2'b01, '0, 64'h40, '0, '0, 4, a5);
    repeat (3) run_round(2'b01, 2'b01, raddr(), raddr(), rblk(), rblk(), 3, rblk());
    run_round(2'b11, 2'b00, 64'h100, '0, rblk(), '0, 2, rblk());
    run_round(2'b01, 2'b00, raddr(), '0, '0, '0, -1, rblk());
    run_round(2'b00, 2'b10, '0, raddr(), '0, rblk(), 1, rblk());
    run_round(2'b01, 2'b00, raddr(), '0, '0, '0, T - 1, rblk());

    // Asynchronous reset in the middle of a port-1 transfer.
    ra = raddr();
    gq.push_back('{1'b1, 1'b0, ra, '0});
    pq.push_back('{-1, '0});
    bus.i_req_addr_1 = ra;
    bus.i_req_read   = 2'b10;
    n = 0;
    do begin
      @(negedge clk);
      drive_cycle();
      n++;
    end while (!(bus.o_start_read | bus.o_start_write) && n < 20);
    chk("reset_test_started", n < 20, 1);
    repeat (3) begin
      @(negedge clk);
      drive_cycle();
    end
    #3 arst = 1'b0;
    #1;
    chk("areset_ctrl", {bus.o_req_done, bus.o_req_timeout, bus.o_start_read,
                        bus.o_start_write, bus.o_busy, bus.o_owner}, 0);
    chk("areset_rsp", bus.o_rsp_block, 0);
    chk("areset_addr", bus.o_addr, 0);
    chk("areset_block", bus.o_block, 0);
    bus.i_req_read = 2'b00; bus.i_req_write = 2'b00; bus.i_done = 1'b0;
    gq.delete(); pq.delete(); cq.delete();
    act = 1'b0; m_prio = 1'b0; m_rsp = '0;
    repeat (2) @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    run_round(2'b01, 2'b01, raddr(), raddr(), rblk(), rblk(), 2, rblk());

    for (int r = 0; r < 40; r++) begin
      logic [1:0] r0, r1;
      r0 = 2'($urandom_range(3));
      r1 = 2'($urandom_range(3));
      if (r0 == 2'b00 && r1 == 2'b00) r0 = 2'b01;
      run_round(r0, r1, raddr(), raddr(), rblk(), rblk(), -2, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
